// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid
// Elastic two-entry pipeline stage (main + skid register) with valid/ready
// handshakes on both sides, plus freeze and flush control. Flushed entries
// reload RESET_VALUE so a flush still looks like a NOP bundle downstream.
// in_ready is derived only from registered state, freeze and flush, so there
// is no combinational path from out_ready back to in_ready.
// Optional feature macro: PIPE_STAGE_STATS_EN adds the stall_count and
// flush_count statistics ports and their saturating counters.

module pipeline_stage_skid #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}},
    parameter int unsigned           CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 freeze,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_main;
    logic [WIDTH-1:0]   r_skid;
    logic               w_accept;
    logic               w_pop;
    logic               w_loadMainIn;
    logic               w_loadMainSkid;
    logic               w_loadSkid;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;
    assign out_data = r_main;

    // State register: EMPTY/HALF/FULL encoding doubles as the occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and data-load decode; flush wins over freeze, and freeze
    // needs no special case because it already masks both handshakes.
    always_comb begin
        w_nextState    = r_state;
        w_loadMainIn   = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        if (flush) begin
            w_nextState = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_nextState  = HALF;
                        w_loadMainIn = 1'b1;
                    end
                end
                HALF: begin
                    if (w_accept && !w_pop) begin
                        w_nextState = FULL;
                        w_loadSkid  = 1'b1;
                    end else if (w_accept && w_pop) begin
                        w_nextState  = HALF;
                        w_loadMainIn = 1'b1;
                    end else if (w_pop) begin
                        w_nextState = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_nextState    = HALF;
                        w_loadMainSkid = 1'b1;
                    end
                end
                default: begin
                    w_nextState = EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs depend only on registered state plus freeze/flush.
    always_comb begin
        in_ready  = (r_state != FULL) && !freeze && !flush;
        out_valid = (r_state != EMPTY) && !freeze;
        occupancy = r_state;
    end

    // Data registers: reload RESET_VALUE on flush, otherwise follow the decode.
    // Popped entries are left in place; out_valid qualifies them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main <= RESET_VALUE;
            r_skid <= RESET_VALUE;
        end else if (flush) begin
            r_main <= RESET_VALUE;
            r_skid <= RESET_VALUE;
        end else begin
            if (w_loadMainIn) begin
                r_main <= in_data;
            end else if (w_loadMainSkid) begin
                r_main <= r_skid;
            end
            if (w_loadSkid) begin
                r_skid <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_WIDTH-1:0] r_stallCount;
    logic [CNT_WIDTH-1:0] r_flushCount;
    logic [CNT_WIDTH:0]   w_flushSum;

    assign w_flushSum  = {1'b0, r_flushCount} + {{(CNT_WIDTH-1){1'b0}}, occupancy};
    assign stall_count = r_stallCount;
    assign flush_count = r_flushCount;

    // Saturating statistics: stalled upstream cycles and entries discarded by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (in_valid && !in_ready && (r_stallCount != {CNT_WIDTH{1'b1}})) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
            if (flush) begin
                r_flushCount <= w_flushSum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}}
                                                      : w_flushSum[CNT_WIDTH-1:0];
            end
        end
    end
`else
    // Statistics disabled: no counter state or ports exist in this build.
`endif

endmodule
